rr_arbiter8: RTL and testbench

Eight-requester round-robin arbiter that shares one downstream resource (bus port, encoder datapath, shared register) among eight clients. It registers a one-hot grant together with its 3-bit binary index, holds the grant until the owner drops its request, and rotates priority so that no requester starves. It sits between the requesting blocks and the shared resource's select/mux input.

---
 rtl/rr_arbiter8.sv | 140 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, hold-until-release and one IDLE gap per handover.
// Optional grant timeout compiled in with `define ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt,
    output logic       dbg_state_o,
    output logic [2:0] dbg_ptr_o
);

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must be in 1..255");
    end

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic [2:0] win;
    logic [2:0] cand;
    logic       win_found;
`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       preempt_q, preempt_d;
`endif

    // Priority search ptr, ptr+1, ... wrapping mod 8; first set request wins.
    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        cand      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            gnt_q     <= 8'h00;
            valid_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // New requests are only evaluated here, so a release edge never hands over directly.
                if (win_found) begin
                    state_d = S_GRANT;
                    idx_d   = win;
                    gnt_d   = 8'h01 << win;
                    valid_d = 1'b1;
                    ptr_d   = win + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            S_GRANT: begin
                if (!req[idx_q]) begin
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                    gnt_d   = 8'h00;
                    valid_d = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                // Owner release takes precedence over a timeout landing on the same edge.
                else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    state_d   = S_IDLE;
                    idx_d     = 3'd0;
                    gnt_d     = 8'h00;
                    valid_d   = 1'b0;
                    preempt_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
                gnt_d   = 8'h00;
                valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        gnt         = gnt_q;
        gnt_idx     = idx_q;
        gnt_valid   = valid_q;
        dbg_state_o = (state_q == S_GRANT);
        dbg_ptr_o   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        preempt     = preempt_q;
`else
        preempt     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: vector table plus hand sequences (timeout path under ARB_TIMEOUT_EN, MAX_HOLD=4)
// and a random-traffic invariant sweep.
module tb_rr_arbiter8;

    localparam int W = 15;  // {gnt[7:0], idx[2:0], preempt, ptr[2:0]}

    typedef struct packed {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       pre;
        logic [2:0] ptr;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;
    logic       dbg_state_o;
    logic [2:0] dbg_ptr_o;

    logic [W-1:0] exp_q[$];
    vec_t         vecs[$];
    int           checks;
    int           errors;
    int           step;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid),
        .preempt    (preempt),
        .dbg_state_o(dbg_state_o),
        .dbg_ptr_o  (dbg_ptr_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic r, input logic [7:0] q, input logic [7:0] g,
                                input logic [2:0] i, input logic p, input logic [2:0] pt);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.gnt   = g;
        v.idx   = i;
        v.pre   = p;
        v.ptr   = pt;
        vecs.push_back(v);
    endfunction

    // driver: drive on negedge, push expectation, compare 1 time unit after the rising edge
    task automatic apply(input logic r, input logic [7:0] q, input logic [7:0] g,
                         input logic [2:0] i, input logic p, input logic [2:0] pt);
        logic [W-1:0] exp_w;
        logic [W-1:0] got_w;
        @(negedge clk);
        rst_n = r;
        req   = q;
        exp_q.push_back({g, i, p, pt});
        @(posedge clk);
        #1;
        step++;
        exp_w = exp_q.pop_front();
        got_w = {gnt, gnt_idx, preempt, dbg_ptr_o};
        checks++;
        if (got_w !== exp_w) begin
            errors++;
            $display("FAIL step %0d outputs: got gnt=%h idx=%0d preempt=%b ptr=%0d, want gnt=%h idx=%0d preempt=%b ptr=%0d",
                     step, got_w[14:7], got_w[6:4], got_w[3], got_w[2:0],
                     exp_w[14:7], exp_w[6:4], exp_w[3], exp_w[2:0]);
        end
        checks++;
        if (gnt_valid !== (exp_w[14:7] != 8'h00)) begin
            errors++;
            $display("FAIL step %0d gnt_valid: got %b want %b", step, gnt_valid, (exp_w[14:7] != 8'h00));
        end
    endtask

    initial begin
        logic [7:0] prev_gnt;
        rst_n  = 1'b0;
        req    = 8'h00;
        checks = 0;
        errors = 0;
        step   = 0;

        // reset with all requests active, then first grant
        add(1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 3'd0);
        add(1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 3'd0);
        add(1'b1, 8'hFF, 8'h01, 3'd0, 1'b0, 3'd1);
        // rotation: owner k drops for one cycle, next grant goes to k+1
        for (int k = 0; k < 8; k++) begin
            add(1'b1, 8'hFF & ~(8'h01 << k), 8'h00, 3'd0, 1'b0, 3'((k + 1) % 8));
            add(1'b1, 8'hFF, 8'h01 << ((k + 1) % 8), 3'((k + 1) % 8), 1'b0, 3'((k + 2) % 8));
        end
        // wrap and ptr
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 3'd1);
        add(1'b1, 8'h40, 8'h40, 3'd6, 1'b0, 3'd7);
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 3'd7);
        add(1'b1, 8'h41, 8'h01, 3'd0, 1'b0, 3'd1);
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 3'd1);
        add(1'b1, 8'h41, 8'h40, 3'd6, 1'b0, 3'd7);
        add(1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 3'd7);
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 3'd7);
        // hold and ignore new arrivals; release edge does not evaluate bit 1
        add(1'b1, 8'h08, 8'h08, 3'd3, 1'b0, 3'd4);
        add(1'b1, 8'h0A, 8'h08, 3'd3, 1'b0, 3'd4);
        add(1'b1, 8'h0A, 8'h08, 3'd3, 1'b0, 3'd4);
        add(1'b1, 8'h02, 8'h00, 3'd0, 1'b0, 3'd4);
        add(1'b1, 8'h02, 8'h02, 3'd1, 1'b0, 3'd2);
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 3'd2);
        // reset mid-grant
        add(1'b1, 8'h20, 8'h20, 3'd5, 1'b0, 3'd6);
        add(1'b0, 8'h20, 8'h00, 3'd0, 1'b0, 3'd0);
        add(1'b1, 8'h20, 8'h20, 3'd5, 1'b0, 3'd6);
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 3'd6);

        foreach (vecs[n])
            apply(vecs[n].rst_n, vecs[n].req, vecs[n].gnt, vecs[n].idx, vecs[n].pre, vecs[n].ptr);

        // timeout sequence: req=05 held from ptr=6
        apply(1'b1, 8'h05, 8'h01, 3'd0, 1'b0, 3'd1);
        for (int n = 0; n < 3; n++) apply(1'b1, 8'h05, 8'h01, 3'd0, 1'b0, 3'd1);
`ifdef ARB_TIMEOUT_EN
        apply(1'b1, 8'h05, 8'h00, 3'd0, 1'b1, 3'd1);
        for (int n = 0; n < 4; n++) apply(1'b1, 8'h05, 8'h04, 3'd2, 1'b0, 3'd3);
        apply(1'b1, 8'h05, 8'h00, 3'd0, 1'b1, 3'd3);
        apply(1'b1, 8'h05, 8'h01, 3'd0, 1'b0, 3'd1);
`else
        for (int n = 0; n < 7; n++) apply(1'b1, 8'h05, 8'h01, 3'd0, 1'b0, 3'd1);
`endif
        // owner releases exactly on the would-be timeout edge: plain release
        for (int n = 0; n < 3; n++) apply(1'b1, 8'h05, 8'h01, 3'd0, 1'b0, 3'd1);
        apply(1'b1, 8'h04, 8'h00, 3'd0, 1'b0, 3'd1);
        apply(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 3'd1);

        // random traffic: one-hot, index consistency, no direct owner-to-owner handover
        prev_gnt = 8'h00;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            req = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            checks++;
            if (!$onehot0(gnt) || (gnt_valid !== (gnt != 8'h00)) ||
                (gnt_valid && gnt !== (8'h01 << gnt_idx)) || (!gnt_valid && gnt_idx !== 3'd0) ||
                (prev_gnt != 8'h00 && gnt != 8'h00 && gnt !== prev_gnt)) begin
                errors++;
                $display("FAIL random %0d invariant: gnt=%h idx=%0d valid=%b prev_gnt=%h", n, gnt, gnt_idx,
                         gnt_valid, prev_gnt);
            end
            prev_gnt = gnt;
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
